// File: rtl/gpio_pkg.sv
// Shared GPIO constants: input width and default debounce timing.
// Also provides a width helper for counters that must be at least 1 bit wide.
package gpio_pkg;

  localparam int GPI_W        = 32;
  localparam int GPI_PRESCALE = 1000;
  localparam int GPI_STABLE   = 4;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpi_db_bit.sv
// One debounced input bit: 2-flop synchronizer, agreement counter and
// accepted level. The counter only advances on the shared sample tick.
module gpi_db_bit
  import gpio_pkg::*;
#(
  parameter int STABLE = GPI_STABLE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(STABLE + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          db_q;
  logic          db_d;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // On each tick: an agreeing sample restarts the run; the STABLE-th
  // consecutive differing sample flips the level and restarts the run.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (tick) begin
      if (sync2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and accepted level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/gpi_debounce.sv
// GPI debounce block: shared sample prescaler, W independent debounced bits
// and optional sticky rising-edge flags.
// Define GPI_EDGE_CAPTURE_EN to build the rise_flags registers; without it
// rise_flags is tied to zero and edge_clr is ignored.
module gpi_debounce
  import gpio_pkg::*;
#(
  parameter int W        = GPI_W,
  parameter int PRESCALE = GPI_PRESCALE,
  parameter int STABLE   = GPI_STABLE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] gpi_raw,
  input  logic [W-1:0] edge_clr,
  output logic [W-1:0] gpi_db,
  output logic [W-1:0] rise_flags
);

  localparam int PW = width_of(PRESCALE);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;

  // Sample tick fires on the last count of each prescaler period.
  always_comb begin
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      gpi_db_bit #(
        .STABLE(STABLE)
      ) u_bit (
        .clk (clk),
        .rst (rst),
        .tick(tick),
        .raw (gpi_raw[gi]),
        .db  (gpi_db[gi])
      );
    end
  endgenerate

`ifdef GPI_EDGE_CAPTURE_EN
  logic [W-1:0] db_prev_q;
  logic [W-1:0] flags_q;
  logic [W-1:0] flags_d;

  // A fresh 0->1 on the level sets the flag; set wins over a same-cycle clear.
  always_comb begin
    flags_d = (flags_q & ~edge_clr) | (gpi_db & ~db_prev_q);
  end

  // Previous level and sticky flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_prev_q <= '0;
      flags_q   <= '0;
    end else begin
      db_prev_q <= gpi_db;
      flags_q   <= flags_d;
    end
  end

  assign rise_flags = flags_q;
`else
  logic unused_edge_clr;

  assign unused_edge_clr = ^edge_clr;
  assign rise_flags      = '0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Self-checking bench for gpi_debounce (W=4, PRESCALE=4, STABLE=3).
// The reference model keeps the last STABLE tick samples per bit and flips
// the expected level when all of them disagree with it.
module tb_gpi_debounce;

  localparam int W = 4;
  localparam int P = 4;
  localparam int S = 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] gpi_raw;
  logic [W-1:0] edge_clr;
  logic [W-1:0] gpi_db;
  logic [W-1:0] rise_flags;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] win[$];
  int           edge_cnt;
  logic [W-1:0] exp_db;
  logic [W-1:0] db_old;
  logic [W-1:0] exp_flags;
  logic [W-1:0] flag_on;

  gpi_debounce #(
    .W       (W),
    .PRESCALE(P),
    .STABLE  (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gpi_raw   (gpi_raw),
    .edge_clr  (edge_clr),
    .gpi_db    (gpi_db),
    .rise_flags(rise_flags)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    raw_hist.delete();
    raw_hist.push_back('0);
    raw_hist.push_back('0);
    win.delete();
    for (int j = 0; j < S; j++) win.push_back('0);
    edge_cnt  = 0;
    exp_db    = '0;
    db_old    = '0;
    exp_flags = '0;
  endtask

  // Drive one cycle of inputs (called at a negedge), advance the model at
  // the posedge, return at the following negedge ready for sampling.
  task automatic step(input logic [W-1:0] raw, input logic [W-1:0] clr);
    logic [W-1:0] smp;
    logic [W-1:0] new_db;
    bit           all_diff;
    gpi_raw  = raw;
    edge_clr = clr;
    @(posedge clk);
    raw_hist.push_back(raw);
    smp = raw_hist[raw_hist.size() - 3];
    while (raw_hist.size() > 3) void'(raw_hist.pop_front());
    edge_cnt++;
    new_db = exp_db;
    if (edge_cnt % P == 0) begin
      win.push_back(smp);
      if (win.size() > S) void'(win.pop_front());
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < win.size(); j++)
          if (win[j][b] == exp_db[b]) all_diff = 1'b0;
        if (all_diff) new_db[b] = ~exp_db[b];
      end
    end
`ifdef GPI_EDGE_CAPTURE_EN
    exp_flags = (exp_flags & ~clr) | (exp_db & ~db_old);
`else
    exp_flags = '0;
`endif
    db_old = exp_db;
    exp_db = new_db;
    @(negedge clk);
    $display("t=%0t raw=%h clr=%h db=%h flags=%h exp_db=%h exp_flags=%h",
             $time, raw, clr, gpi_db, rise_flags, exp_db, exp_flags);
  endtask

  task automatic do_reset(input logic [W-1:0] raw);
    gpi_raw  = raw;
    edge_clr = '0;
    #2;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    gpi_raw  = 4'hF;
    edge_clr = '0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (gpi_db !== 4'h0 || rise_flags !== 4'h0) begin
      bad++;
      $display("FAIL reset_async db=%h flags=%h want 0/0", gpi_db, rise_flags);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (gpi_db !== 4'h0 || rise_flags !== 4'h0) begin
        bad++;
        $display("FAIL reset_hold db=%h flags=%h want 0/0", gpi_db, rise_flags);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(4'hF, 4'h0);
      total++;
      if (gpi_db !== exp_db || rise_flags !== exp_flags) begin
        bad++;
        $display("FAIL reset_rel db=%h flags=%h want %h/%h", gpi_db, rise_flags, exp_db, exp_flags);
      end
      if (i == 9) begin
        total++;
        if (gpi_db !== 4'h0) begin
          bad++;
          $display("FAIL reset_min_latency db=%h want 0", gpi_db);
        end
      end
    end
    total++;
    if (gpi_db !== 4'hF) begin
      bad++;
      $display("FAIL reset_max_latency db=%h want f", gpi_db);
    end
    total++;
    if (rise_flags !== flag_on) begin
      bad++;
      $display("FAIL reset_flags flags=%h want %h", rise_flags, flag_on);
    end
  endtask

  task automatic test_glitch();
    do_reset(4'h0);
    for (int i = 0; i < 28; i++) begin
      step((i < 8) ? 4'h1 : 4'h0, 4'h0);
      total++;
      if (gpi_db !== exp_db || rise_flags !== exp_flags || gpi_db[0] !== 1'b0 || rise_flags[0] !== 1'b0) begin
        bad++;
        $display("FAIL glitch db=%h flags=%h want %h/%h", gpi_db, rise_flags, exp_db, exp_flags);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset(4'h0);
    for (int i = 0; i < 50; i++) begin
      step((i >= 30 || ((i / 3) % 2 == 1)) ? 4'h2 : 4'h0, 4'h0);
      total++;
      if (gpi_db !== exp_db || rise_flags !== exp_flags) begin
        bad++;
        $display("FAIL bounce db=%h flags=%h want %h/%h", gpi_db, rise_flags, exp_db, exp_flags);
      end
    end
    total++;
    if (gpi_db[1] !== 1'b1) begin
      bad++;
      $display("FAIL bounce_settled db1=%b want 1", gpi_db[1]);
    end
  endtask

  task automatic test_clear_race();
    bit hit;
    hit = 1'b0;
    do_reset(4'h0);
    for (int i = 0; i < 30 && !hit; i++) begin
      if (exp_db[2] && !db_old[2]) begin
        step(4'h4, 4'h4);
        hit = 1'b1;
        total++;
        if (rise_flags[2] !== flag_on[2]) begin
          bad++;
          $display("FAIL race_set_wins flag2=%b want %b", rise_flags[2], flag_on[2]);
        end
      end else begin
        step(4'h4, 4'h0);
        total++;
        if (gpi_db !== exp_db || rise_flags !== exp_flags) begin
          bad++;
          $display("FAIL race_pre db=%h flags=%h want %h/%h", gpi_db, rise_flags, exp_db, exp_flags);
        end
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL race_timeout rise not seen got=0 want=1");
    end
    step(4'h4, 4'h4);
    total++;
    if (rise_flags[2] !== 1'b0 || rise_flags !== exp_flags) begin
      bad++;
      $display("FAIL race_clear flags=%h want %h", rise_flags, exp_flags);
    end
    step(4'h4, 4'h0);
    total++;
    if (rise_flags[2] !== 1'b0) begin
      bad++;
      $display("FAIL race_stays_clear flag2=%b want 0", rise_flags[2]);
    end
  endtask

  task automatic test_fall();
    do_reset(4'h8);
    for (int i = 0; i < 32; i++) begin
      step((i < 16) ? 4'h8 : 4'h0, 4'h0);
      total++;
      if (gpi_db !== exp_db || rise_flags !== exp_flags) begin
        bad++;
        $display("FAIL fall db=%h flags=%h want %h/%h", gpi_db, rise_flags, exp_db, exp_flags);
      end
    end
    total++;
    if (gpi_db[3] !== 1'b0 || rise_flags[3] !== flag_on[3]) begin
      bad++;
      $display("FAIL fall_final db3=%b flag3=%b want 0/%b", gpi_db[3], rise_flags[3], flag_on[3]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'h0);
    for (int i = 0; i < 7; i++) step(4'hF, 4'h0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (gpi_db !== 4'h0 || rise_flags !== 4'h0) begin
      bad++;
      $display("FAIL reset_mid_async db=%h flags=%h want 0/0", gpi_db, rise_flags);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(4'hF, 4'h0);
      total++;
      if (gpi_db !== exp_db || rise_flags !== exp_flags) begin
        bad++;
        $display("FAIL reset_mid db=%h flags=%h want %h/%h", gpi_db, rise_flags, exp_db, exp_flags);
      end
    end
    total++;
    if (gpi_db !== 4'hF || rise_flags !== flag_on) begin
      bad++;
      $display("FAIL reset_mid_final db=%h flags=%h want f/%h", gpi_db, rise_flags, flag_on);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] lvl;
    logic [W-1:0] clr;
    int           hold[W];
    lvl = '0;
    do_reset(4'h0);
    for (int b = 0; b < W; b++) hold[b] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = ~lvl[b];
          hold[b] = int'($urandom_range(1, 24));
        end
        hold[b]--;
        clr[b] = ($urandom_range(0, 7) == 0);
      end
      step(lvl, clr);
      total++;
      if (gpi_db !== exp_db || rise_flags !== exp_flags) begin
        bad++;
        $display("FAIL random db=%h flags=%h want %h/%h", gpi_db, rise_flags, exp_db, exp_flags);
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b0;
    gpi_raw  = '0;
    edge_clr = '0;
`ifdef GPI_EDGE_CAPTURE_EN
    flag_on = 4'hF;
`else
    flag_on = 4'h0;
`endif
    model_reset();
    @(negedge clk);
    test_reset();
    test_glitch();
    test_bounce();
    test_clear_race();
    test_fall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
REQ-001 SHALL have parameter W, default 32: number of input bits conditioned.
REQ-002 SHALL have parameter PRESCALE, default 1000: clk cycles per sample tick, legal range >=1.
REQ-003 SHALL have parameter STABLE, default 4: consecutive differing samples required to accept a new level, legal range >=1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 gpi_raw  input  W  asynchronous external pins.
REQ-007 edge_clr  input  W  per-bit clear mask for rise_flags, sampled every cycle.
REQ-008 gpi_db  output  W  debounced level; drives gpi1/gpi2 of the GPIO block.
REQ-009 rise_flags  output  W  sticky rising-edge flags of gpi_db.

Function
REQ-010 gpi_raw SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-011 Prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert internal tick in the cycle count==PRESCALE-1; PRESCALE=1 gives tick every cycle.
REQ-012 Per bit, on tick: synced==gpi_db -> counter cleared to 0; else counter+1.
REQ-013 When counter+1 reaches STABLE on a tick, gpi_db[i] SHALL take the synced value and counter SHALL clear, in the same edge.
REQ-014 A glitch shorter than STABLE consecutive ticks SHALL never change gpi_db; any agreeing sample restarts the count.
REQ-015 Counters SHALL saturate-free: width clog2(STABLE+1), never exceeding STABLE.
REQ-016 Latency raw->gpi_db SHALL be 2 cycles sync plus STABLE ticks (at most 2+STABLE*PRESCALE cycles, at least 2+(STABLE-1)*PRESCALE+1).
REQ-017 Bits SHALL be fully independent; simultaneous changes on several bits each follow REQ-012/013.
REQ-018 rise_flags[i] SHALL set the cycle after gpi_db[i] goes 0->1 and hold until cleared.
REQ-019 edge_clr[i]=1 SHALL clear rise_flags[i] next edge; simultaneous set and clear -> set wins.
REQ-020 Falling edges SHALL not affect rise_flags.

Reset
REQ-021 rst low SHALL immediately clear synchronizer flops, prescaler, counters, gpi_db, rise_flags to 0.
REQ-022 Reset asserted mid-count SHALL discard partial counts; after release, prescaler restarts at 0 and a held-high input reaches gpi_db after REQ-016 latency, setting rise_flags.

Configuration
REQ-023 Macro GPI_EDGE_CAPTURE_EN defined: rise_flags logic per REQ-018..020 present.
REQ-024 Macro undefined: rise_flags SHALL be constant 0, edge_clr ignored, no flag registers synthesized; ports remain.

Structure
REQ-025 Package gpio_pkg SHALL hold GPI_W=32, default PRESCALE and STABLE constants, shared with the GPIO top.
REQ-026 Per-bit synchronizer + counter + level SHALL be one sub-module gpi_db_bit, instantiated W times by generate; prescaler and flags stay in gpi_debounce.

Verification (W=4, PRESCALE=4, STABLE=3)
REQ-027 Reset: rst low with gpi_raw=4'hF -> gpi_db=0, rise_flags=0 throughout; release -> gpi_db=4'hF within 2+12 cycles, rise_flags=4'hF.
REQ-028 Glitch: bit0 high for 8 cycles (2 ticks) then low -> gpi_db[0] stays 0, rise_flags[0] stays 0.
REQ-029 Bounce: bit1 toggles every 3 cycles for 30 cycles then held 1 -> gpi_db[1] rises only after 3 consecutive high ticks after settling.
REQ-030 Clear race: edge_clr[2]=1 in the same cycle rise_flags[2] would set -> rise_flags[2]=1; edge_clr[2] pulse a cycle later -> 0.
REQ-031 Fall: held-high bit3 driven low -> gpi_db[3]=0 after 3 ticks, rise_flags[3] unchanged.
REQ-032 Macro off build: repeat REQ-027 -> rise_flags constant 0, gpi_db identical.
